blink_scheduler: RTL and testbench

Configuration controller for the blinker bank. It accepts byte commands over a valid/ready port, stages per-channel phase offsets and a channel-enable mask, and applies staged values only at the free-running counter's wrap, so blinker outputs never glitch mid-period. It sits between the top-level `ui_in` command path and the `blinker` instances: it drives their `offset` inputs and gates their outputs through an enable mask. An optional chase mode rotates the enable mask once per counter period.

---
 rtl/blink_pkg.sv | 27 ++
 rtl/blink_wrap_detect.sv | 32 +++
 rtl/blink_scheduler.sv | 168 ++++++++++++++++
 tb/tb_blink_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// -----------------------------------------------------------------------------
// blink_pkg
// Shared constants and types for the blinker-bank configuration scheduler.
//   MAX_CH        : largest channel count the 2-bit channel field can address
//   CNT_W         : width of the shared free-running counter
//   OP_*          : command header opcodes (header bits [7:6])
//   sched_state_t : command/apply FSM states
// -----------------------------------------------------------------------------
package blink_pkg;

    localparam int MAX_CH = 4;
    localparam int CNT_W  = 16;

    localparam logic [1:0] OP_SET_OFFSET = 2'b00;
    localparam logic [1:0] OP_SET_MASK   = 2'b01;
    localparam logic [1:0] OP_CHASE      = 2'b10;
    localparam logic [1:0] OP_CLEAR      = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        DATA_HI,
        DATA_LO,
        MASK,
        WAIT_WRAP
    } sched_state_t;

endpackage

// File: rtl/blink_wrap_detect.sv
// -----------------------------------------------------------------------------
// blink_wrap_detect
// Registers a free-running counter and flags its rollover. The flag is high
// for the single cycle in which the counter reads lower than last cycle, i.e.
// the cycle it shows 0 after FFFF.
// Ports:
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset (registered count clears to 0)
//   i_cnt  : live counter value
//   o_wrap : one-cycle rollover pulse (combinational from i_cnt and register)
// -----------------------------------------------------------------------------
import blink_pkg::*;

module blink_wrap_detect #(
    parameter int W = CNT_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_cnt,
    output logic         o_wrap
);

    logic [W-1:0] r_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_cnt_q <= '0;
        else       r_cnt_q <= i_cnt;
    end

    assign o_wrap = (i_cnt < r_cnt_q);

endmodule

// File: rtl/blink_scheduler.sv
// -----------------------------------------------------------------------------
// blink_scheduler
// Accepts byte commands, stages per-channel phase offsets and a channel-enable
// mask, and commits staged values only at the shared counter's rollover so the
// blinkers never change phase mid-period.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   cnt_in      : shared counter value
//   cmd_valid   : command byte valid
//   cmd_ready   : byte can be accepted (low while an update waits for a wrap)
//   cmd_data    : command byte; header = {op[1:0], ch[1:0], 3'bx, chase_en}
//   offset_out  : live offsets, channel i at [16i+15:16i]
//   en_mask     : live channel enables
//   busy        : a staged update is waiting for the next wrap
// Build option:
//   BLINK_SCHED_CHASE_EN : enables the CHASE opcode and per-wrap mask rotation;
//                          without it opcode 10 is accepted and ignored.
// -----------------------------------------------------------------------------
import blink_pkg::*;

module blink_scheduler #(
    parameter int NUM_CH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNT_W-1:0]      cnt_in,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd_data,
    output logic [16*NUM_CH-1:0]  offset_out,
    output logic [NUM_CH-1:0]     en_mask,
    output logic                  busy
);

    sched_state_t r_state, w_next;

    logic                        w_wrap;
    logic                        w_fire;
    logic [1:0]                  w_op;
    logic                        w_hdr;
    logic                        w_clear;
    logic                        w_apply;

    logic [1:0]                  r_chan;
    logic                        r_is_mask;
    logic [15:0]                 r_shadow_off;
    logic [NUM_CH-1:0]           r_shadow_mask;
    logic [NUM_CH-1:0][15:0]     r_off;
    logic [NUM_CH-1:0]           r_mask;

    blink_wrap_detect #(.W(CNT_W)) u_wrap (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_cnt  (cnt_in),
        .o_wrap (w_wrap)
    );

    assign cmd_ready = (r_state != WAIT_WRAP);
    assign busy      = (r_state == WAIT_WRAP);

    assign w_fire  = cmd_valid & cmd_ready;
    assign w_op    = cmd_data[7:6];
    assign w_hdr   = w_fire & (r_state == IDLE);
    assign w_clear = w_hdr & (w_op == OP_CLEAR);
    // Only a wrap seen while already waiting commits; a wrap in the cycle the
    // last data byte lands is deliberately skipped.
    assign w_apply = (r_state == WAIT_WRAP) & w_wrap;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_fire) begin
                    case (w_op)
                        OP_SET_OFFSET: w_next = DATA_HI;
                        OP_SET_MASK:   w_next = MASK;
                        default:       w_next = IDLE;
                    endcase
                end
            end
            DATA_HI:   if (w_fire) w_next = DATA_LO;
            DATA_LO:   if (w_fire) w_next = WAIT_WRAP;
            MASK:      if (w_fire) w_next = WAIT_WRAP;
            WAIT_WRAP: if (w_wrap) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- staging
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chan        <= '0;
            r_is_mask     <= 1'b0;
            r_shadow_off  <= '0;
            r_shadow_mask <= '0;
        end else if (w_fire) begin
            case (r_state)
                IDLE: begin
                    r_chan    <= cmd_data[5:4];
                    r_is_mask <= (w_op == OP_SET_MASK);
                end
                DATA_HI: r_shadow_off[15:8] <= cmd_data;
                DATA_LO: r_shadow_off[7:0]  <= cmd_data;
                MASK:    r_shadow_mask      <= cmd_data[NUM_CH-1:0];
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- offsets
    // Channels at or above NUM_CH never match, so their writes drop silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_off <= '0;
        end else if (w_clear) begin
            r_off <= '0;
        end else if (w_apply && !r_is_mask) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_chan == 2'(i)) r_off[i] <= r_shadow_off;
            end
        end
    end

    assign offset_out = r_off;

    // ---------------------------------------------------------------- mask
`ifdef BLINK_SCHED_CHASE_EN
    logic              r_chase_on;
    logic [NUM_CH-1:0] w_rot;

    // Rotate left by one; with a single channel this degenerates to identity.
    always_comb begin
        w_rot = r_mask;
        for (int i = 0; i < NUM_CH; i++) begin
            w_rot[i] = r_mask[(i + NUM_CH - 1) % NUM_CH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            r_chase_on <= 1'b0;
        else if (w_clear)                   r_chase_on <= 1'b0;
        else if (w_hdr && w_op == OP_CHASE) r_chase_on <= cmd_data[0];
    end

    // A mask committed on a wrap replaces the rotation for that wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          r_mask <= '1;
        else if (w_clear)                 r_mask <= '1;
        else if (w_apply && r_is_mask)    r_mask <= r_shadow_mask;
        else if (r_chase_on && w_wrap)    r_mask <= w_rot;
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          r_mask <= '1;
        else if (w_clear)                 r_mask <= '1;
        else if (w_apply && r_is_mask)    r_mask <= r_shadow_mask;
    end
`endif

    assign en_mask = r_mask;

endmodule

// File: tb/tb_blink_scheduler.sv
// -----------------------------------------------------------------------------
// tb_blink_scheduler
// Directed bench for blink_scheduler (NUM_CH = 4). The bench owns cnt_in and
// advances it by one after every rising edge, jumping it close to FFFF when a
// long wait is not of interest. Build option BLINK_SCHED_CHASE_EN selects the
// chase section.
// -----------------------------------------------------------------------------
module tb_blink_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cnt_in;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_data;
    logic [63:0] offset_out;
    logic [3:0]  en_mask;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    blink_scheduler #(.NUM_CH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .offset_out (offset_out),
        .en_mask    (en_mask),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs and samples both sit 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        cnt_in = cnt_in + 16'd1;
    endtask

    task automatic send(input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_data  = b;
        cyc();
        cmd_valid = 1'b0;
    endtask

    // Leaves cnt_in presenting 0000 (the wrap cycle), before the commit edge.
    task automatic run_to_zero();
        int n;
        n = 0;
        while (cnt_in != 16'h0000 && n < 70000) begin
            cyc();
            n++;
        end
        chk("run_to_zero_bound", 64'(cnt_in), 64'h0);
    endtask

    task automatic wrap_now();
        cnt_in = 16'hFFFC;
        run_to_zero();
        cyc();
    endtask

    initial begin
        int busy_low;
        int n;
        logic [3:0] exp_rot [4];

        rst       = 1'b1;
        cnt_in    = 16'h8000;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        #12;
        chk("rst_offset", offset_out, 64'h0);
        chk("rst_mask",   64'(en_mask), 64'hF);
        chk("rst_ready",  64'(cmd_ready), 64'h1);
        chk("rst_busy",   64'(busy), 64'h0);
        cyc();
        cyc();
        rst    = 1'b0;
        cnt_in = 16'h8000;

        // SET_OFFSET ch1 = 0x1234, full half-period wait
        send(8'h10);
        send(8'h12);
        send(8'h34);
        chk("off1_busy",  64'(busy), 64'h1);
        chk("off1_ready", 64'(cmd_ready), 64'h0);
        busy_low = 0;
        n = 0;
        while (cnt_in != 16'h0000 && n < 70000) begin
            if (!busy) busy_low++;
            cyc();
            n++;
        end
        chk("off1_wait_cycles", 64'(n), 64'd32765);
        chk("off1_busy_held",   64'(busy_low), 64'h0);
        chk("off1_pre_apply",   offset_out, 64'h0);
        cyc();
        chk("off1_applied", offset_out, 64'h0000_0000_1234_0000);
        chk("off1_busy_done", 64'(busy), 64'h0);
        chk("off1_ready_done", 64'(cmd_ready), 64'h1);

        // SET_MASK 0101 with a CLEAR held on the port while waiting
        send(8'h40);
        send(8'h05);
        chk("mask_busy", 64'(busy), 64'h1);
        cmd_valid = 1'b1;
        cmd_data  = 8'hC0;
        cnt_in    = 16'hFFFC;
        run_to_zero();
        chk("mask_ready_low", 64'(cmd_ready), 64'h0);
        chk("mask_pre_apply", 64'(en_mask), 64'hF);
        cyc();
        cmd_valid = 1'b0;
        chk("mask_applied",   64'(en_mask), 64'h5);
        chk("mask_no_clear",  offset_out, 64'h0000_0000_1234_0000);

        // Last data byte lands on the wrap cycle: that wrap must be skipped
        cnt_in = 16'hFFFE;
        send(8'h00);
        send(8'hBE);
        send(8'hEF);
        chk("skipwrap_busy",    64'(busy), 64'h1);
        chk("skipwrap_offset",  offset_out, 64'h0000_0000_1234_0000);
        wrap_now();
        chk("skipwrap_applied", offset_out, 64'h0000_0000_1234_BEEF);
        chk("skipwrap_mask",    64'(en_mask), 64'h5);

        // Reset in DATA_LO
        send(8'h20);
        send(8'hAB);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_ready",  64'(cmd_ready), 64'h1);
        chk("midrst_busy",   64'(busy), 64'h0);
        chk("midrst_offset", offset_out, 64'h0);
        chk("midrst_mask",   64'(en_mask), 64'hF);
        cyc();
        rst    = 1'b0;
        cnt_in = 16'h1000;
        send(8'h30);
        send(8'h56);
        send(8'h78);
        chk("postrst_busy", 64'(busy), 64'h1);
        wrap_now();
        chk("postrst_applied", offset_out, 64'h5678_0000_0000_0000);

        // Mask 0110, then CLEAR away from any wrap
        send(8'h40);
        send(8'h06);
        wrap_now();
        chk("mask6_applied", 64'(en_mask), 64'h6);
        cnt_in = 16'h4000;
        send(8'hC0);
        chk("clear_offset", offset_out, 64'h0);
        chk("clear_mask",   64'(en_mask), 64'hF);
        chk("clear_busy",   64'(busy), 64'h0);

        send(8'h40);
        send(8'h01);
        wrap_now();
        chk("mask1_applied", 64'(en_mask), 64'h1);
`ifdef BLINK_SCHED_CHASE_EN
        exp_rot[0] = 4'b0010;
        exp_rot[1] = 4'b0100;
        exp_rot[2] = 4'b1000;
        exp_rot[3] = 4'b0001;
        send(8'h81);
        chk("chase_no_wrap", 64'(en_mask), 64'h1);
        for (int k = 0; k < 4; k++) begin
            wrap_now();
            chk($sformatf("chase_rot%0d", k), 64'(en_mask), 64'(exp_rot[k]));
        end
        send(8'h40);
        send(8'h03);
        wrap_now();
        chk("chase_mask_wins", 64'(en_mask), 64'h3);
        wrap_now();
        chk("chase_after_apply", 64'(en_mask), 64'h6);
        send(8'hC0);
        chk("chase_clear_mask", 64'(en_mask), 64'hF);
        send(8'h40);
        send(8'h01);
        wrap_now();
        wrap_now();
        chk("chase_off_after_clear", 64'(en_mask), 64'h1);
`else
        exp_rot[0] = 4'b0001;
        send(8'h81);
        chk("nop_ready", 64'(cmd_ready), 64'h1);
        chk("nop_busy",  64'(busy), 64'h0);
        wrap_now();
        chk("nop_mask_static", 64'(en_mask), 64'(exp_rot[0]));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
